mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the instruction-fetch path and the data path of the single-cycle-decoded MIPS core.
- The data path is driven by the decoder's readmem/writemem strobes.
- Arbitrates requests, sequences the memory handshake, returns read data and a one-cycle acknowledge per requester.
- Sits between the fetch unit / load-store path and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory buses of the memory port arbiter
// Signals: if_req/if_addr/if_rdata/if_ack (fetch), dm_read/dm_write/dm_addr/dm_wdata/dm_rdata/dm_ack
// (load/store), mem_en/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready (memory), err (watchdog pulse).
// master: the arbiter's view; slave: the requesters plus memory model.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          dm_read;
   logic          dm_write;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          err;
   modport master (
      input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, err
   );
   modport slave (
      output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between instruction fetch and load/store
// Ports: clock (rising edge), reset (asynchronous, active-low), bus (mem_port_arbiter_if.master)
// carrying the fetch request/ack/rdata, data read/write/ack/rdata, memory strobe/address/data/ready and err.
// Optional feature: define MEMARB_TIMEOUT_EN to add an access watchdog of TIMEOUT_CYCLES stalled
// cycles that ends the access with zero read data and an err pulse; otherwise err is tied to 0.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
`ifdef MEMARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input logic                clock,
   input logic                reset,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);
   state_t        state_q, state_d;
   logic          owner_q, owner_d;   // 1 = data path owns the access
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;
   logic [3:0]    starve_q, starve_d;
   logic          dm_req, pick_dm;
`ifdef MEMARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] wd_q, wd_d;
   logic          err_q, err_d;
`endif
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      starve_d   = starve_q;
      dm_req     = bus.dm_read | bus.dm_write;
      // a waiting fetch wins once the data path has taken STARVE_MAX grants in a row
      pick_dm    = dm_req & (~bus.if_req | (starve_q != SMAX));
`ifdef MEMARB_TIMEOUT_EN
      wd_d       = wd_q;
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: if (dm_req | bus.if_req) begin
            state_d  = ACCESS;
            owner_d  = pick_dm;
            // read+write together is a write
            we_d     = pick_dm & bus.dm_write;
            addr_d   = pick_dm ? bus.dm_addr : bus.if_addr;
            wdata_d  = bus.dm_wdata;
            // only data grants that leave a fetch waiting count towards starvation
            starve_d = (pick_dm & bus.if_req) ? ((starve_q == SMAX) ? SMAX : starve_q + 4'd1) : 4'd0;
`ifdef MEMARB_TIMEOUT_EN
            wd_d     = '0;
            err_d    = 1'b0;
`endif
         end
         ACCESS: if (bus.mem_ready) begin
            state_d    = RESP;
            if_rdata_d = owner_q ? if_rdata_q : bus.mem_rdata;
            dm_rdata_d = (owner_q & ~we_q) ? bus.mem_rdata : dm_rdata_q;
         end
`ifdef MEMARB_TIMEOUT_EN
         else if (wd_q == WD_LAST) begin
            state_d    = RESP;
            err_d      = 1'b1;
            if_rdata_d = owner_q ? if_rdata_q : '0;
            dm_rdata_d = owner_q ? '0 : dm_rdata_q;
         end else begin
            wd_d = wd_q + 1'b1;
         end
`endif
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         starve_q   <= '0;
`ifdef MEMARB_TIMEOUT_EN
         wd_q       <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         starve_q   <= starve_d;
`ifdef MEMARB_TIMEOUT_EN
         wd_q       <= wd_d;
         err_q      <= err_d;
`endif
      end
   end
   assign bus.mem_en    = state_q == ACCESS;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_ack    = (state_q == RESP) & ~owner_q;
   assign bus.dm_ack    = (state_q == RESP) & owner_q;
`ifdef MEMARB_TIMEOUT_EN
   assign bus.err       = (state_q == RESP) & err_q;
`else
   assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
   localparam int SM = 2;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   int starve = 0;
   logic [31:0] mdl_mem [256];
   logic [31:0] exp_if_rd = '0;
   logic [31:0] exp_dm_rd = '0;
   bit glog[$];
   bit exp_order[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
   mem_port_arbiter #(
      .AW(32),
      .DW(32),
      .STARVE_MAX(SM)
`ifdef MEMARB_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(5)
`endif
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic new_reqs(input int odds);
      int k;
      if (!bus.if_req && $urandom_range(odds - 1) == 0) begin
         bus.if_req  = 1'b1;
         bus.if_addr = 32'($urandom_range(255));
      end
      if (!(bus.dm_read || bus.dm_write) && $urandom_range(odds - 1) == 0) begin
         k = $urandom_range(2);
         bus.dm_read  = k != 1;
         bus.dm_write = k != 0;
         bus.dm_addr  = 32'($urandom_range(255));
         bus.dm_wdata = $urandom;
      end
   endtask
   // Called at an IDLE-cycle negedge with requests already driven; returns at the next IDLE negedge.
   task automatic serve(input int waits, input bit keep, input bit rnd);
      bit g_dm, we;
      logic [31:0] a, wd, rd;
      if (!(bus.dm_read || bus.dm_write || bus.if_req)) begin
         @(negedge clock);
         check("idle_en", bus.mem_en, 0);
         check("idle_acks", {bus.if_ack, bus.dm_ack}, 0);
         return;
      end
      g_dm = (bus.dm_read || bus.dm_write) && (!bus.if_req || starve != SM);
      starve = (g_dm && bus.if_req) ? ((starve < SM) ? starve + 1 : SM) : 0;
      a  = g_dm ? bus.dm_addr : bus.if_addr;
      we = g_dm && bus.dm_write;
      wd = bus.dm_wdata;
      rd = mdl_mem[a[7:0]];
      for (int w = 0; w <= waits; w++) begin
         @(negedge clock);
         check("acc_en", bus.mem_en, 1);
         check("acc_addr", bus.mem_addr, a);
         check("acc_we", bus.mem_we, we);
         if (we) check("acc_wdata", bus.mem_wdata, wd);
         check("acc_acks", {bus.if_ack, bus.dm_ack}, 0);
         bus.mem_ready = w == waits;
         bus.mem_rdata = (w == waits) ? rd : $urandom;
         if (rnd) new_reqs(4);
      end
      @(negedge clock);
      bus.mem_ready = 1'b0;
      if (!g_dm) exp_if_rd = rd;
      else if (!we) exp_dm_rd = rd;
      else mdl_mem[a[7:0]] = wd;
      check("resp_if_ack", bus.if_ack, !g_dm);
      check("resp_dm_ack", bus.dm_ack, g_dm);
      check("resp_en", bus.mem_en, 0);
      check("resp_err", bus.err, 0);
      check("if_rdata", bus.if_rdata, exp_if_rd);
      check("dm_rdata", bus.dm_rdata, exp_dm_rd);
      glog.push_back(bus.dm_ack);
      if (!keep) begin
         if (g_dm) begin
            bus.dm_read  = 1'b0;
            bus.dm_write = 1'b0;
         end else begin
            bus.if_req = 1'b0;
         end
      end
      @(negedge clock);
      check("post_acks", {bus.if_ack, bus.dm_ack}, 0);
      check("post_en", bus.mem_en, 0);
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mdl_mem[i] = $urandom;
      bus.if_req = 0; bus.if_addr = 0; bus.dm_read = 0; bus.dm_write = 0;
      bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
      repeat (2) @(negedge clock);
      check("rst_en", bus.mem_en, 0);
      check("rst_we", bus.mem_we, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_acks", {bus.if_ack, bus.dm_ack}, 0);
      check("rst_if_rdata", bus.if_rdata, 0);
      check("rst_dm_rdata", bus.dm_rdata, 0);
      check("rst_err", bus.err, 0);
      reset = 1'b1;
      @(negedge clock);
      mdl_mem[8'h10] = 32'h8C220004;
      bus.if_req = 1; bus.if_addr = 32'h10;
      serve(0, 0, 0);
      bus.dm_write = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEADBEEF;
      serve(3, 0, 0);
      bus.dm_read = 1; bus.dm_addr = 32'h40;
      serve(1, 0, 0);
      check("rdback_40", bus.dm_rdata, 32'hDEADBEEF);
      bus.dm_read = 1; bus.dm_write = 1; bus.dm_addr = 32'h8; bus.dm_wdata = 32'h12345678;
      serve(0, 0, 0);
      bus.dm_read = 1; bus.dm_addr = 32'h8;
      serve(2, 0, 0);
      check("rdback_08", bus.dm_rdata, 32'h12345678);
      glog.delete();
      bus.dm_read = 1; bus.dm_addr = 32'h20; bus.if_req = 1; bus.if_addr = 32'h30;
      repeat (6) serve(0, 1, 0);
      bus.dm_read = 0; bus.if_req = 0;
      for (int i = 0; i < 6; i++) check($sformatf("order%0d", i), 32'(glog[i]), 32'(exp_order[i]));
      bus.dm_read = 1; bus.dm_addr = 32'h5;
      @(negedge clock);
      check("rstacc_en", bus.mem_en, 1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rstacc_en_drop", bus.mem_en, 0);
      check("rstacc_acks", {bus.if_ack, bus.dm_ack}, 0);
      bus.dm_read = 0;
      @(negedge clock);
      reset = 1'b1;
      starve = 0; exp_if_rd = '0; exp_dm_rd = '0;
      repeat (3) begin
         @(negedge clock);
         check("after_rst_en", bus.mem_en, 0);
         check("after_rst_acks", {bus.if_ack, bus.dm_ack}, 0);
      end
      check("after_rst_dm_rdata", bus.dm_rdata, 0);
`ifdef MEMARB_TIMEOUT_EN
      bus.dm_read = 1; bus.dm_addr = 32'h7; bus.mem_ready = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("to_en", bus.mem_en, 1);
         check("to_pre_ack", bus.dm_ack, 0);
         check("to_pre_err", bus.err, 0);
      end
      @(negedge clock);
      check("to_ack", bus.dm_ack, 1);
      check("to_if_ack", bus.if_ack, 0);
      check("to_err", bus.err, 1);
      check("to_rdata", bus.dm_rdata, 0);
      bus.dm_read = 0;
      @(negedge clock);
      check("to_post_err", bus.err, 0);
      check("to_post_ack", bus.dm_ack, 0);
`endif
      repeat (300) begin
         new_reqs(2);
         serve($urandom_range(3), 0, 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
